// File: rtl/weight_stream_mem.sv
// Weight store: sequential load port, then streams all NUM_WEIGHT words out over a valid/ready port.
// Optional build macro WMEM_WRAP_EN: streaming wraps to word 0 continuously until stop is seen.
module weight_stream_mem #(
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] win,
  output logic                  loaded,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WEIGHT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] rptr_nxt;
  logic                  load_en;
  logic                  launch;
  logic                  advance;
  logic                  rewind;
  logic                  finish;
  logic                  hs;
  logic                  stop_req;

  assign busy     = (state_q == STREAM);
  assign hs       = rd_valid & rd_ready;
  assign load_en  = wen & (state_q == IDLE);
  assign rptr_nxt = rptr + 1'b1;

`ifdef WMEM_WRAP_EN
  logic stop_pending;

  assign stop_req = stop | stop_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      stop_pending <= 1'b0;
    end else if (finish || state_q == IDLE) begin
      stop_pending <= 1'b0;
    end else if (stop) begin
      stop_pending <= 1'b1;
    end
  end
`else
  logic unused_stop;

  assign unused_stop = stop;
  assign stop_req    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    advance = 1'b0;
    rewind  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && loaded) begin
          state_d = STREAM;
          launch  = 1'b1;
        end
      end
      STREAM: begin
        if (hs) begin
          if (!rd_last) begin
            advance = 1'b1;
          end else if (stop_req) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            rewind = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory has no reset: contents survive rst by design.
  always_ff @(posedge clk) begin
    if (!rst && load_en) mem[wptr] <= win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      loaded   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load_en) begin
        if (wptr == LAST) begin
          wptr   <= '0;
          loaded <= 1'b1;
        end else begin
          wptr <= wptr + 1'b1;
        end
      end
      if (launch || rewind) begin
        rptr     <= '0;
        rd_data  <= mem[0];
        rd_valid <= 1'b1;
        rd_last  <= 1'b0;
      end else if (advance) begin
        rptr    <= rptr_nxt;
        rd_data <= mem[rptr_nxt];
        rd_last <= (rptr_nxt == LAST);
      end else if (finish) begin
        rptr     <= '0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_mem.sv
// Directed bench for weight_stream_mem: load, stream, stalls, ignored controls, wrap, and reset abort.
module tb_weight_stream_mem;

  localparam int N = 30;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wen = 1'b0;
  logic [W-1:0] win = '0;
  logic         loaded;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         busy;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic         done;

  int tests = 0;
  int fails = 0;

  weight_stream_mem #(.NUM_WEIGHT(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .wen(wen), .win(win), .loaded(loaded),
    .start(start), .stop(stop), .busy(busy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({loaded, busy, rd_valid, rd_last, done, rd_data} !== '0) begin
      fails++;
      $display("FAIL reset: loaded=%b busy=%b valid=%b last=%b done=%b data=%0d, required all 0",
               loaded, busy, rd_valid, rd_last, done, rd_data);
    end
  endtask

  task automatic test_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL start_unloaded: busy=%b valid=%b, required 0 0", busy, rd_valid);
    end
    for (int i = 1; i <= N; i++) begin
      wen = 1'b1;
      win = W'(i);
      tick();
      tests++;
      if (loaded !== (i == N)) begin
        fails++;
        $display("FAIL load_%0d: loaded=%b, required %b", i, loaded, (i == N));
      end
    end
    wen = 1'b0;
    tests++;
    if (dut.wptr !== '0) begin
      fails++;
      $display("FAIL wptr_wrap: wptr=%0d, required 0", dut.wptr);
    end
  endtask

  task automatic test_stream();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_ready = 1'b1;
    for (int k = 1; k <= N; k++) begin
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== W'(k) || rd_last !== (k == N) || busy !== 1'b1) begin
        fails++;
        $display("FAIL stream_%0d: valid=%b data=%0d last=%b busy=%b, required 1 %0d %b 1",
                 k, rd_valid, rd_data, rd_last, busy, k, (k == N));
      end
      stop  = (k == 5);
      start = (k == N);
      tick();
    end
    stop  = 1'b0;
    start = 1'b0;
    rd_ready = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: done=%b busy=%b valid=%b, required 1 0 0", done, busy, rd_valid);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL start_on_last: done=%b busy=%b valid=%b, required 0 0 0", done, busy, rd_valid);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat = 4'b1001;
    int exp = 1;
    int c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (exp <= N && c < 200) begin
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== W'(exp) || rd_last !== (exp == N)) begin
        fails++;
        $display("FAIL stall_c%0d: valid=%b data=%0d last=%b, required 1 %0d %b",
                 c, rd_valid, rd_data, rd_last, exp, (exp == N));
      end
      rd_ready = pat[c % 4];
      start = (c == 3);
      stop  = (c == 6);
      tick();
      if (rd_ready) exp++;
      c++;
    end
    rd_ready = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tests++;
    if (exp <= N || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_end: words=%0d done=%b busy=%b, required %0d 1 0", exp - 1, done, busy, N);
    end
    tick();
  endtask

  task automatic test_wen_during_stream();
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      rd_ready = 1'b1;
      wen = (pass == 0);
      win = 16'hBEEF;
      for (int k = 1; k <= N; k++) begin
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== W'(k)) begin
          fails++;
          $display("FAIL wen_stream_p%0d_%0d: valid=%b data=%0d, required 1 %0d",
                   pass, k, rd_valid, rd_data, k);
        end
        stop = (k == 2);
        tick();
      end
      wen = 1'b0;
      stop = 1'b0;
      rd_ready = 1'b0;
      tests++;
      if (done !== 1'b1 || loaded !== 1'b1 || dut.wptr !== '0) begin
        fails++;
        $display("FAIL wen_stream_end_p%0d: done=%b loaded=%b wptr=%0d, required 1 1 0",
                 pass, done, loaded, dut.wptr);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
`ifdef WMEM_WRAP_EN
    int total = 2 * N;
    int stop_at = N + 4;
`else
    int total = N;
    int stop_at = 4;
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_ready = 1'b1;
    for (int n = 0; n < total; n++) begin
      int exp = (n % N) + 1;
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== W'(exp) || rd_last !== (exp == N) || done !== 1'b0) begin
        fails++;
        $display("FAIL wrap_%0d: valid=%b data=%0d last=%b done=%b, required 1 %0d %b 0",
                 n, rd_valid, rd_data, rd_last, done, exp, (exp == N));
      end
      stop = (n == stop_at);
      tick();
    end
    stop = 1'b0;
    rd_ready = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_end: done=%b busy=%b valid=%b, required 1 0 0", done, busy, rd_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_ready = 1'b1;
    for (int k = 1; k < 10; k++) tick();
    tests++;
    if (rd_data !== W'(10)) begin
      fails++;
      $display("FAIL rst_mid_pre: data=%0d, required 10", rd_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({loaded, busy, rd_valid, rd_last, done, rd_data} !== '0) begin
      fails++;
      $display("FAIL rst_mid: loaded=%b busy=%b valid=%b last=%b done=%b data=%0d, required all 0",
               loaded, busy, rd_valid, rd_last, done, rd_data);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_start: busy=%b valid=%b, required 0 0", busy, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_stall();
    test_wen_during_stream();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_stream_mem.md
WEIGHT_STREAM_MEM -- requirements
Module: weight_stream_mem

Interface
REQ-001 SHALL have parameter NUM_WEIGHT, default 30: number of weight words stored (≥2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: weight word width, signed fixed-point, opaque to this block.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_WEIGHT): load/read pointer width.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wen, input, 1: load strobe; win is written when high.
REQ-007 SHALL have port win, input, DATA_WIDTH: load data.
REQ-008 SHALL have port loaded, output, 1: high once all NUM_WEIGHT words have been written since reset.
REQ-009 SHALL have port start, input, 1: single-cycle request to stream all weights.
REQ-010 SHALL have port stop, input, 1: ends continuous streaming (REQ-030 only).
REQ-011 SHALL have port busy, output, 1: high while in STREAM.
REQ-012 SHALL have port rd_valid, output, 1: rd_data is valid.
REQ-013 SHALL have port rd_ready, input, 1: consumer accepts rd_data.
REQ-014 SHALL have port rd_data, output, DATA_WIDTH: current weight word.
REQ-015 SHALL have port rd_last, output, 1: rd_data is word NUM_WEIGHT-1.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a stream completes.

Function
REQ-017 SHALL implement FSM states IDLE and STREAM; reset state IDLE.
REQ-018 In IDLE, wen SHALL write win to mem[wptr] and increment wptr; writing at wptr=NUM_WEIGHT-1 SHALL wrap wptr to 0 and set loaded the next cycle.
REQ-019 Further loads after loaded=1 SHALL overwrite from wptr=0 onward; loaded SHALL stay high.
REQ-020 wen in STREAM SHALL be ignored (no write, wptr unchanged).
REQ-021 start in IDLE with loaded=1 SHALL enter STREAM, set rptr=0, and drive rd_valid=1 with rd_data=mem[0] in the following cycle.
REQ-022 start with loaded=0, or start while in STREAM, SHALL be ignored.
REQ-023 rd_data, rd_valid and rd_last SHALL be registered and SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-024 A handshake (rd_valid & rd_ready) SHALL advance rptr and present the next word in the next cycle, giving a sustained throughput of one word per cycle.
REQ-025 rd_last SHALL be high only alongside word NUM_WEIGHT-1.
REQ-026 A handshake on the last word SHALL, the next cycle: return to IDLE, clear rd_valid and busy, and pulse done for one cycle (unless REQ-030 applies).
REQ-027 start and a last-word handshake in the same cycle SHALL NOT begin a new stream; start is dropped.

Reset
REQ-028 rst SHALL force IDLE and clear wptr, rptr, loaded, busy, rd_valid, rd_last and done, and set rd_data to 0; memory contents are not cleared.
REQ-029 rst mid-stream or mid-load SHALL abort immediately; loaded=0 requires a full reload before the next start is accepted.

Configuration
REQ-030 With WMEM_WRAP_EN defined, a last-word handshake without stop SHALL wrap rptr to 0 and continue streaming mem[0] (rd_last pulses once per pass, no done). stop in STREAM SHALL end the stream at the next last-word handshake, with done then pulsing; stop in IDLE SHALL be ignored.
REQ-031 Without WMEM_WRAP_EN, behaviour SHALL follow REQ-026 and stop SHALL be ignored.

Verification
REQ-032 Reset, then 30 wen writes of values 1..30 -> loaded rises the cycle after the 30th write; wptr is back at 0.
REQ-033 start with rd_ready held at 1 -> rd_data is 1..30 on 30 consecutive cycles, rd_last with 30, done one cycle later, busy low.
REQ-034 rd_ready toggled 1,0,0,1 during a stream -> no word is lost or duplicated; rd_data is stable during stalls.
REQ-035 start before load completes, and a wen during STREAM -> start is ignored; memory is unchanged, as confirmed by a later stream.
REQ-036 rst asserted at word 10 of a stream -> the next cycle all outputs are 0, loaded is 0, and a subsequent start is ignored.
REQ-037 With WMEM_WRAP_EN, start then stop at word 5 of pass 2 -> sequence 1..30,1..30, done after the second rd_last; without the macro -> a single pass only.
